// File: rtl/fpu_mul_add_sequencer_pkg.sv
// rtl/fpu_mul_add_sequencer_pkg.sv - shared FPU op codes, sequencer states and constants
//
// Purpose : shared definitions for the multiply/add sequencer and its op decoder.
// Contents: op encodings, sequencer state encoding, canonical quiet NaN,
//           and the widths of the fused-product side channel.
package fpu_mul_add_sequencer_pkg;

  localparam logic [2:0] OP_FADD  = 3'b000;
  localparam logic [2:0] OP_FSUB  = 3'b001;
  localparam logic [2:0] OP_FMUL  = 3'b010;
  localparam logic [2:0] OP_FMADD = 3'b011;
  localparam logic [2:0] OP_FMSUB = 3'b100;

  localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

  localparam int FUSE_EXP_W = 11;
  localparam int FUSE_SIG_W = 48;
  localparam int CLASS_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_FMA_ADD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/fpu_mul_add_sequencer_op_decode.sv
// rtl/fpu_mul_add_sequencer_op_decode.sv - combinational op classifier for the sequencer
//
// Purpose : classifies a 3-bit FPU op code.
// Ports   : op      in  3  operation code
//           isFused out 1  FMADD or FMSUB (product then add)
//           negB    out 1  flip sign of the adder B operand taken from rs2 (FSUB)
//           negC    out 1  flip sign of the adder B operand taken from rs3 (FMSUB)
//           illegal out 1  op code outside the defined set
module fpu_op_decode
  import fpu_mul_add_sequencer_pkg::*;
(
  input  logic [2:0] op,
  output logic       isFused,
  output logic       negB,
  output logic       negC,
  output logic       illegal
);

  assign isFused = (op == OP_FMADD) || (op == OP_FMSUB);
  assign negB    = (op == OP_FSUB);
  assign negC    = (op == OP_FMSUB);
  assign illegal = (op > OP_FMSUB);

endmodule

// File: rtl/fpu_mul_add_sequencer.sv
// rtl/fpu_mul_add_sequencer.sv - sequences FADD/FSUB/FMUL/FMADD/FMSUB over shared mul and add units
//
// Purpose : accepts one FP request at a time, steers latched operands to an
//           external multiplier and adder, and registers the final result.
// Ports   : clk_i, rst_i (async, active-high)
//           valid_i/ready_o      request handshake; op_i, rm_i, rs1_i..rs3_i request fields
//           result_o/valid_o/ready_i  registered result handshake
//           busy_o               not idle
//           rm_o                 latched rounding mode to both units
//           mulA_o/mulB_o        multiplier operands; mulOut_i/mulExp_i/mulSig_i/mulClass_i results
//           addA_o/addB_o        adder operands; addFuse_o selects fused product as adder A
//           fuseExp_o/fuseSig_o/fuseClass_o  registered unrounded product
//           addOut_i             adder result
module fpu_mul_add_sequencer
  import fpu_mul_add_sequencer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            op_i,
  input  logic [2:0]            rm_i,
  input  logic [31:0]           rs1_i,
  input  logic [31:0]           rs2_i,
  input  logic [31:0]           rs3_i,
  output logic [31:0]           result_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic [2:0]            rm_o,
  output logic [31:0]           mulA_o,
  output logic [31:0]           mulB_o,
  input  logic [31:0]           mulOut_i,
  input  logic [FUSE_EXP_W-1:0] mulExp_i,
  input  logic [FUSE_SIG_W-1:0] mulSig_i,
  input  logic [CLASS_W-1:0]    mulClass_i,
  output logic [31:0]           addA_o,
  output logic [31:0]           addB_o,
  output logic                  addFuse_o,
  output logic [FUSE_EXP_W-1:0] fuseExp_o,
  output logic [FUSE_SIG_W-1:0] fuseSig_o,
  output logic [CLASS_W-1:0]    fuseClass_o,
  input  logic [31:0]           addOut_i
);

  state_t state, state_nxt;

  logic [2:0]            op_q;
  logic [2:0]            rm_q;
  logic [31:0]           rs1_q, rs2_q, rs3_q;
  logic [31:0]           result_q;
  logic [FUSE_EXP_W-1:0] fuse_exp_q;
  logic [FUSE_SIG_W-1:0] fuse_sig_q;
  logic [CLASS_W-1:0]    fuse_class_q;

  logic        accept;
  logic        ld_result;
  logic        ld_fuse;
  logic [31:0] result_nxt;

  logic is_fused, neg_b, neg_c, illegal;
  logic is_addsub;

  // Decode the latched op; the live op_i is only relevant on the accept edge.
  fpu_op_decode u_op_decode (
    .op      (op_q),
    .isFused (is_fused),
    .negB    (neg_b),
    .negC    (neg_c),
    .illegal (illegal)
  );

  assign is_addsub = (op_q == OP_FADD) || (op_q == OP_FSUB);

  assign ready_o = (state == ST_IDLE) && !rst_i;
  assign accept  = valid_i && ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ld_result  = 1'b0;
    ld_fuse    = 1'b0;
    result_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_fused) begin
          // Capture the unrounded product; the add happens next cycle.
          ld_fuse   = 1'b1;
          state_nxt = ST_FMA_ADD;
        end else begin
          ld_result = 1'b1;
          state_nxt = ST_DONE;
          if (illegal) begin
            result_nxt = CANON_QNAN;
          end else if (op_q == OP_FMUL) begin
            result_nxt = mulOut_i;
          end else begin
            result_nxt = addOut_i;
          end
        end
      end
      ST_FMA_ADD: begin
        ld_result  = 1'b1;
        result_nxt = addOut_i;
        state_nxt  = ST_DONE;
      end
      ST_DONE: begin
        if (ready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q         <= '0;
      rm_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs3_q        <= '0;
      result_q     <= '0;
      fuse_exp_q   <= '0;
      fuse_sig_q   <= '0;
      fuse_class_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= op_i;
        rm_q  <= rm_i;
        rs1_q <= rs1_i;
        rs2_q <= rs2_i;
        rs3_q <= rs3_i;
      end
      if (ld_fuse) begin
        fuse_exp_q   <= mulExp_i;
        fuse_sig_q   <= mulSig_i;
        fuse_class_q <= mulClass_i;
      end
      if (ld_result) begin
        result_q <= result_nxt;
      end
    end
  end

  // Adder B: subtraction is an addition with the sign of the subtrahend flipped.
  always_comb begin
    addB_o = '0;
    if (is_addsub) begin
      addB_o = {rs2_q[31] ^ neg_b, rs2_q[30:0]};
    end else if (is_fused) begin
      addB_o = {rs3_q[31] ^ neg_c, rs3_q[30:0]};
    end
  end

  assign addA_o      = is_addsub ? rs1_q : '0;
  assign addFuse_o   = (state == ST_FMA_ADD);
  assign mulA_o      = rs1_q;
  assign mulB_o      = rs2_q;
  assign rm_o        = rm_q;
  assign fuseExp_o   = fuse_exp_q;
  assign fuseSig_o   = fuse_sig_q;
  assign fuseClass_o = fuse_class_q;
  assign result_o    = result_q;
  assign valid_o     = (state == ST_DONE);
  assign busy_o      = (state != ST_IDLE);

endmodule
